// File: rtl/mp8_pkg.sv
// Shared definitions for the MP-8 boot loader: memory geometry, loader
// state encoding and the running checksum helper.
package mp8_pkg;

    localparam int MP8_DEPTH = 32;
    localparam int MP8_AW    = 5;

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        LEN     = 4'd1,
        DATA    = 4'd2,
        CSUM    = 4'd3,
        CLEAR   = 4'd4,
        RELEASE = 4'd5,
        START   = 4'd6,
        DONE    = 4'd7,
        ERR     = 4'd8
    } mp8_state_e;

    // Modulo-256 running sum used as the frame checksum.
    function automatic logic [7:0] csum_add(input logic [7:0] sum, input logic [7:0] b);
        csum_add = sum + b;
    endfunction

endpackage

// File: rtl/mp8_stall_timer.sv
// Saturating stall counter with clear, load and a terminal flag.
// 'last' is high when one more stalled cycle reaches LIMIT, so the owner
// can leave its waiting state on the same edge the limit is reached.
module mp8_stall_timer #(
    parameter int TW    = 8,
    parameter int LIMIT = 255
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    input  logic          load,
    input  logic [TW-1:0] load_val,
    input  logic          inc,
    output logic          last
);

    localparam logic [TW-1:0] LAST_C = TW'((LIMIT > 0) ? (LIMIT - 1) : 0);
    localparam logic [TW-1:0] MAX_C  = {TW{1'b1}};
    localparam logic [TW-1:0] ONE_C  = TW'(1);

    logic [TW-1:0] count_r;

    // Stall count: clear beats load, load beats increment; holds at all-ones.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_r <= {TW{1'b0}};
        end else if (clr) begin
            count_r <= {TW{1'b0}};
        end else if (load) begin
            count_r <= load_val;
        end else if (inc && (count_r != MAX_C)) begin
            count_r <= count_r + ONE_C;
        end else begin
            count_r <= count_r;
        end
    end

    assign last = (count_r == LAST_C);

endmodule

// File: rtl/mp8_program_loader.sv
// MP-8 boot loader: receives a length/payload/checksum frame, writes the
// payload from address 0, optionally zero-fills the rest of memory, then
// releases the core from reset and issues a single start pulse.
module mp8_program_loader
    import mp8_pkg::*;
#(
    parameter int DEPTH      = MP8_DEPTH,
    parameter int AW         = MP8_AW,
    parameter bit CLEAR_REST = 1'b1,
    parameter int TIMEOUT    = 255
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load_req,
    input  logic          in_valid,
    input  logic [7:0]    in_data,
    output logic          in_ready,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [7:0]    mem_wdata,
    output logic          cpu_reset,
    output logic          cpu_start,
    output logic          busy,
    output logic          done,
    output logic          err
);

    // One extra bit so a length equal to DEPTH is representable.
    localparam int            LW      = AW + 1;
    localparam logic [LW-1:0] DEPTH_C = LW'(DEPTH);
    localparam logic [LW-1:0] LAST_C  = LW'(DEPTH - 1);
    localparam logic [LW-1:0] ONE_C   = LW'(1);
    localparam logic [7:0]    DEPTH_B = 8'(DEPTH);

    mp8_state_e    state_r, state_s;
    logic [LW-1:0] len_r, cnt_r;
    logic [7:0]    sum_r;
    logic          xfer_s, active_s, stall_last_s, timeout_s;
    logic          cpu_reset_s, cpu_start_s, busy_s, done_s, err_s;

    assign active_s  = (state_r == LEN) || (state_r == DATA) || (state_r == CSUM);
    assign in_ready  = active_s;
    assign xfer_s    = in_valid && active_s;
    assign timeout_s = (TIMEOUT > 0) && active_s && !xfer_s && stall_last_s;

    mp8_stall_timer #(
        .TW    (8),
        .LIMIT (TIMEOUT)
    ) u_stall (
        .clk      (clk),
        .reset    (reset),
        .clr      (xfer_s || !active_s),
        .load     (1'b0),
        .load_val (8'h00),
        .inc      (active_s && !xfer_s),
        .last     (stall_last_s)
    );

    // State and state-decoded outputs; outputs follow the state being entered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= IDLE;
            cpu_reset <= 1'b1;
            cpu_start <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state_r   <= state_s;
            cpu_reset <= cpu_reset_s;
            cpu_start <= cpu_start_s;
            busy      <= busy_s;
            done      <= done_s;
            err       <= err_s;
        end
    end

    // Next-state logic; a stall timeout overrides any waiting state.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (load_req) state_s = LEN;
                else          state_s = IDLE;
            end
            LEN: begin
                if (timeout_s) begin
                    state_s = ERR;
                end else if (xfer_s) begin
                    if ((in_data == 8'h00) || (in_data > DEPTH_B)) state_s = ERR;
                    else                                           state_s = DATA;
                end else begin
                    state_s = LEN;
                end
            end
            DATA: begin
                if (timeout_s)                               state_s = ERR;
                else if (xfer_s && (cnt_r == len_r - ONE_C)) state_s = CSUM;
                else                                         state_s = DATA;
            end
            CSUM: begin
                if (timeout_s) begin
                    state_s = ERR;
                end else if (xfer_s) begin
                    if (in_data != sum_r)                      state_s = ERR;
                    else if (CLEAR_REST && (len_r < DEPTH_C)) state_s = CLEAR;
                    else                                       state_s = RELEASE;
                end else begin
                    state_s = CSUM;
                end
            end
            CLEAR: begin
                if (cnt_r == LAST_C) state_s = RELEASE;
                else                 state_s = CLEAR;
            end
            RELEASE: state_s = START;
            START:   state_s = DONE;
            DONE: begin
                if (load_req) state_s = LEN;
                else          state_s = DONE;
            end
            ERR: begin
                if (load_req) state_s = LEN;
                else          state_s = ERR;
            end
            default: state_s = IDLE;
        endcase
    end

    // Output decode of the state about to be entered.
    always_comb begin
        cpu_reset_s = 1'b1;
        cpu_start_s = 1'b0;
        busy_s      = 1'b0;
        done_s      = 1'b0;
        err_s       = 1'b0;
        case (state_s)
            LEN, DATA, CSUM, CLEAR: busy_s = 1'b1;
            RELEASE: begin
                cpu_reset_s = 1'b0;
                busy_s      = 1'b1;
            end
            START: begin
                cpu_reset_s = 1'b0;
                cpu_start_s = 1'b1;
                busy_s      = 1'b1;
            end
            DONE: begin
                cpu_reset_s = 1'b0;
                done_s      = 1'b1;
            end
            ERR:     err_s       = 1'b1;
            default: cpu_reset_s = 1'b1;
        endcase
    end

    // Frame datapath and registered memory write port.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            len_r     <= {LW{1'b0}};
            cnt_r     <= {LW{1'b0}};
            sum_r     <= 8'h00;
            mem_we    <= 1'b0;
            mem_addr  <= {AW{1'b0}};
            mem_wdata <= 8'h00;
        end else begin
            mem_we <= 1'b0;
            case (state_r)
                LEN: begin
                    if (xfer_s) begin
                        len_r <= in_data[LW-1:0];
                        cnt_r <= {LW{1'b0}};
                        sum_r <= 8'h00;
                    end
                end
                DATA: begin
                    if (xfer_s) begin
                        mem_we    <= 1'b1;
                        mem_addr  <= cnt_r[AW-1:0];
                        mem_wdata <= in_data;
                        sum_r     <= csum_add(sum_r, in_data);
                        cnt_r     <= cnt_r + ONE_C;
                    end
                end
                CLEAR: begin
                    mem_we    <= 1'b1;
                    mem_addr  <= cnt_r[AW-1:0];
                    mem_wdata <= 8'h00;
                    cnt_r     <= cnt_r + ONE_C;
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mp8_program_loader.sv
// Directed bench for the MP-8 boot loader (built with a 4-cycle stall limit).
module tb_mp8_program_loader;

    logic       clk = 1'b0;
    logic       reset;
    logic       load_req;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       mem_we;
    logic [4:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       cpu_reset;
    logic       cpu_start;
    logic       busy;
    logic       done;
    logic       err;

    always #5 clk = ~clk;

    mp8_program_loader #(
        .DEPTH      (32),
        .AW         (5),
        .CLEAR_REST (1'b1),
        .TIMEOUT    (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .load_req  (load_req),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_reset (cpu_reset),
        .cpu_start (cpu_start),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Write / start-pulse monitor, sampled on the falling edge.
    int         wr_n      = 0;
    int         start_n   = 0;
    int         start_bad = 0;
    logic       prev_rst  = 1'b1;
    logic [4:0] wr_a [0:255];
    logic [7:0] wr_d [0:255];

    always @(negedge clk) begin
        if (mem_we) begin
            wr_a[wr_n & 255] = mem_addr;
            wr_d[wr_n & 255] = mem_wdata;
            wr_n = wr_n + 1;
        end
        if (cpu_start) begin
            start_n = start_n + 1;
            if (cpu_reset || prev_rst) start_bad = start_bad + 1;
        end
        prev_rst = cpu_reset;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic pulse_load();
        load_req = 1'b1;
        tick();
        load_req = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = b;
        check_eq("in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_end(input int maxc);
        int c;
        c = 0;
        while (!(done || err) && c < maxc) begin
            tick();
            c++;
        end
        check_eq("end_reached", {31'd0, done | err}, 32'd1);
    endtask

    int         base;
    int         sbase;
    logic [7:0] d1 [0:2];
    logic [7:0] b;
    logic [7:0] sum;

    initial begin
        reset    = 1'b1;
        load_req = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        d1[0] = 8'h21; d1[1] = 8'h42; d1[2] = 8'hF0;
        #1;
        check_eq("rst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        check_eq("rst_outs", {24'd0, cpu_start, busy, done, err, in_ready, mem_we, 2'b00}, 32'd0);
        check_eq("rst_mem", {19'd0, mem_addr, mem_wdata}, 32'd0);
        idle(2);
        reset = 1'b0;
        idle(2);
        check_eq("idle_ready", {31'd0, in_ready}, 32'd0);

        // Good 3-byte frame with zero-fill.
        base = wr_n; sbase = start_n;
        pulse_load();
        check_eq("t1_busy", {31'd0, busy}, 32'd1);
        check_eq("t1_rst_held", {31'd0, cpu_reset}, 32'd1);
        send_byte(8'h03);
        send_byte(8'h21);
        send_byte(8'h42);
        send_byte(8'hF0);
        send_byte(8'h53);
        wait_end(100);
        check_eq("t1_nwr", wr_n - base, 32'd32);
        for (int i = 0; i < 3; i++) begin
            check_eq("t1_addr", {27'd0, wr_a[(base + i) & 255]}, i);
            check_eq("t1_data", {24'd0, wr_d[(base + i) & 255]}, {24'd0, d1[i]});
        end
        for (int i = 3; i < 32; i++) begin
            check_eq("t1_clr_addr", {27'd0, wr_a[(base + i) & 255]}, i);
            check_eq("t1_clr_data", {24'd0, wr_d[(base + i) & 255]}, 32'd0);
        end
        check_eq("t1_starts", start_n - sbase, 32'd1);
        check_eq("t1_start_order", start_bad, 32'd0);
        check_eq("t1_done", {31'd0, done}, 32'd1);
        check_eq("t1_flags", {29'd0, busy, err, cpu_reset}, 32'd0);
        idle(3);
        check_eq("t1_done_sticky", {31'd0, done}, 32'd1);

        // Restart from DONE, then bad checksum.
        base = wr_n; sbase = start_n;
        pulse_load();
        check_eq("t2_restart", {29'd0, cpu_reset, done, busy}, 32'b101);
        send_byte(8'h03);
        send_byte(8'h21);
        send_byte(8'h42);
        send_byte(8'hF0);
        send_byte(8'h54);
        wait_end(20);
        idle(5);
        check_eq("t2_err", {31'd0, err}, 32'd1);
        check_eq("t2_state", {28'd0, cpu_reset, done, busy, in_ready}, 32'b1000);
        check_eq("t2_nwr", wr_n - base, 32'd3);
        check_eq("t2_starts", start_n - sbase, 32'd0);

        // Illegal lengths 0 and 33.
        base = wr_n;
        pulse_load();
        check_eq("t3_err_cleared", {31'd0, err}, 32'd0);
        send_byte(8'h00);
        check_eq("t3_len0_err", {30'd0, err, busy}, 32'b10);
        pulse_load();
        send_byte(8'h21);
        check_eq("t3_len33_err", {30'd0, err, busy}, 32'b10);
        idle(3);
        check_eq("t3_nwr", wr_n - base, 32'd0);

        // Full 32-byte frame with gaps, wrapping checksum, load_req while busy.
        base = wr_n; sbase = start_n;
        pulse_load();
        send_byte(8'h20);
        sum = 8'h00;
        for (int i = 0; i < 32; i++) begin
            idle(i % 3);
            if (i == 10) begin
                load_req = 1'b1;
                tick();
                load_req = 1'b0;
                check_eq("t4_busy_ignore", {30'd0, busy, in_ready}, 32'b11);
            end
            b   = 8'(i * 37 + 5);
            sum = sum + b;
            send_byte(b);
        end
        send_byte(sum);
        wait_end(20);
        check_eq("t4_nwr", wr_n - base, 32'd32);
        for (int i = 0; i < 32; i++) begin
            b = 8'(i * 37 + 5);
            check_eq("t4_addr", {27'd0, wr_a[(base + i) & 255]}, i);
            check_eq("t4_data", {24'd0, wr_d[(base + i) & 255]}, {24'd0, b});
        end
        check_eq("t4_done", {29'd0, done, err, busy}, 32'b100);
        check_eq("t4_starts", start_n - sbase, 32'd1);

        // Stall timeout after the length byte.
        base = wr_n;
        pulse_load();
        send_byte(8'h02);
        idle(3);
        check_eq("t5_pre_timeout", {30'd0, err, in_ready}, 32'b01);
        tick();
        check_eq("t5_timeout", {30'd0, err, in_ready}, 32'b10);
        check_eq("t5_nwr", wr_n - base, 32'd0);

        // Asynchronous reset in the middle of DATA.
        pulse_load();
        send_byte(8'h05);
        send_byte(8'hAA);
        send_byte(8'hBB);
        check_eq("t6_write_live", {31'd0, mem_we}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check_eq("t6_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        check_eq("t6_outs", {24'd0, cpu_start, busy, done, err, in_ready, mem_we, 2'b00}, 32'd0);
        check_eq("t6_mem", {19'd0, mem_addr, mem_wdata}, 32'd0);
        base = wr_n;
        idle(2);
        reset = 1'b0;
        idle(5);
        check_eq("t6_nwr", wr_n - base, 32'd0);
        check_eq("t6_idle", {29'd0, cpu_reset, busy, in_ready}, 32'b100);

        check_eq("start_order", start_bad, 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mp8_program_loader.md
Name: mp8_program_loader

Overview:
Boot-time writer for the MP-8 program/data memory. Accepts a framed byte stream (length, payload, checksum) and writes the payload to memory from address 0. Holds the CPU in reset throughout, then releases it and issues the one-cycle start pulse the controller waits for in its reset state. Sits between the host/debug byte link and the MP-8 memory write port and CPU reset/start pins.

Parameters:
DEPTH, 32, memory words; matches the 5-bit instruction address field
AW, 5, address width, log2(DEPTH)
CLEAR_REST, 1, 1 = zero-fill addresses len..DEPTH-1 after a good checksum
TIMEOUT, 255, stall cycles allowed between accepted bytes; 0 = disabled

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
load_req  in  1  request a new load; sampled in IDLE, DONE, ERR
in_valid  in  1  stream byte valid
in_data  in  8  stream byte
in_ready  out  1  loader accepts byte this cycle
mem_we  out  1  memory write enable (registered)
mem_addr  out  AW  memory write address (registered)
mem_wdata  out  8  memory write data (registered)
cpu_reset  out  1  active-high reset to MP-8 core
cpu_start  out  1  one-cycle start pulse to MP-8 controller
busy  out  1  load in progress
done  out  1  load finished, CPU started; sticky until next load_req
err  out  1  load failed; sticky until next load_req

Behaviour:
- Reset values: cpu_reset=1, all other outputs 0; state IDLE; len, cnt, sum, stall counter = 0.
- Byte transfer = in_valid & in_ready. in_ready=1 only in LEN, DATA, CSUM.
- States:
  - IDLE: load_req -> LEN.
  - LEN: on transfer of L: L==0 or L>DEPTH -> ERR; else len=L, cnt=0, sum=0 -> DATA.
  - DATA: on transfer of b: write b at addr cnt; sum=(sum+b) mod 256; cnt++. The transfer with cnt==len-1 -> CSUM.
  - CSUM: on transfer of c: c!=sum -> ERR. Else CLEAR_REST && len<DEPTH -> CLEAR, otherwise -> RELEASE.
  - CLEAR: one write per cycle of 0x00 to addresses len..DEPTH-1, ascending. After writing DEPTH-1 -> RELEASE.
  - RELEASE: one cycle -> START.
  - START: one cycle -> DONE.
  - DONE: load_req -> LEN.
  - ERR: load_req -> LEN.
- Memory writes are registered: mem_we/mem_addr/mem_wdata are valid in the cycle after the DATA transfer or CLEAR step. mem_we is 1 for exactly one cycle per write. mem_addr/mem_wdata hold their value when mem_we=0.
- State-decoded outputs are registered and change on the edge entering the state:
  - cpu_reset=0 only in RELEASE, START, DONE.
  - cpu_start=1 only in START, so the core is out of reset one full cycle before start.
  - busy=1 in LEN..START.
  - done=1 in DONE.
  - err=1 in ERR.
- Timeout (TIMEOUT>0): in LEN/DATA/CSUM, the stall counter increments each cycle with no transfer and clears on each transfer. Reaching TIMEOUT -> ERR.
- load_req while busy is ignored. load_req in DONE/ERR clears done/err and reasserts cpu_reset on the next edge.
- Bytes presented outside LEN/DATA/CSUM are not consumed (in_ready=0).
- Asynchronous reset mid-operation: immediate return to reset values. Memory contents are unspecified; no further writes occur.
- ERR leaves already-written memory as is; the CPU stays in reset.

Decomposition:
- Shared package mp8_pkg: state encoding constants (IDLE, LEN, DATA, CSUM, CLEAR, RELEASE, START, DONE, ERR), MP8_DEPTH=32, MP8_AW=5.
- One natural sub-module: mp8_stall_timer (loadable saturating counter with clear and terminal flag), used for the timeout.
- All else in a single FSM module.

Test Plan:
- load_req; bytes 03,21,42,F0,53 -> writes (0,21),(1,42),(2,F0); then 29 zero writes to addr 3..31; cpu_reset falls; cpu_start=1 for exactly one cycle one cycle later; done=1, busy=0.
- Same frame with checksum 54 -> err=1; cpu_reset stays 1; cpu_start never asserted; exactly 3 data writes.
- Length byte 00 -> err immediately, no writes. Repeat with length byte 21 (33) -> err.
- Length 20 (32) with random in_valid gaps and a checksum that wraps past FF -> 32 writes, no CLEAR phase, done=1.
- TIMEOUT=4: length 02, then in_valid=0 for 4 cycles -> err=1, in_ready=0.
- Assert reset mid-DATA -> all outputs at reset values, including cpu_reset=1. load_req while busy is ignored. load_req in DONE restarts with cpu_reset=1 and done=0 on the next edge.
